// File: rtl/fetch_unit_pkg.sv
// Shared CPU pipeline constants: exception codes, address map defaults, and PC source encoding.
package fetch_unit_pkg;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] IM_LO_DEF      = 32'h0000_3000;
    localparam logic [31:0] IM_HI_DEF      = 32'h0000_6FFC;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    typedef enum logic [2:0] {
        PC_SRC_SEQ,
        PC_SRC_HOLD,
        PC_SRC_REDIRECT,
        PC_SRC_PENDING,
        PC_SRC_HANDLER,
        PC_SRC_EPC
    } pc_src_e;

    // Sequential increment wraps modulo 2^32; the wrapped address is caught by the range check.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_addr_check.sv
// Combinational fetch address legality: misaligned or outside the instruction window raises AdEL.
module fetch_addr_check
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] IM_LO = IM_LO_DEF,
    parameter logic [31:0] IM_HI = IM_HI_DEF
) (
    input  logic [31:0] pc,
    output logic        adel
);

    logic misaligned;
    logic below_lo;
    logic above_hi;

    assign misaligned = |pc[1:0];
    assign below_lo   = pc < IM_LO;
    assign above_hi   = pc > IM_HI;
    assign adel       = misaligned | below_lo | above_hi;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register with redirect priority, one-entry stalled-redirect buffer,
// and fetch-side address exception reporting.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter logic [31:0] IM_LO      = IM_LO_DEF,
    parameter logic [31:0] IM_HI      = IM_HI_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        is_bj_D,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PC_4F,
    output logic [6:2]  ExcCodeF,
    output logic        if_bdF,
    output logic        pending_o
);

    logic [31:0] pc_q, pc_d;
    logic        pending_q, pending_d;
    logic [31:0] target_q, target_d;
    logic        bd_sup_q, bd_sup_d;
    pc_src_e     pc_src;
    logic        adel;

    always_comb begin
        pc_src = PC_SRC_SEQ;
        if (exc_req) begin
            pc_src = PC_SRC_HANDLER;
        end else if (eret_req) begin
            pc_src = PC_SRC_EPC;
        end else if (!en) begin
            pc_src = PC_SRC_HOLD;
        end else if (redirect_valid) begin
            pc_src = PC_SRC_REDIRECT;
        end else if (pending_q) begin
            pc_src = PC_SRC_PENDING;
        end
    end

    always_comb begin
        pc_d      = pc_q;
        pending_d = pending_q;
        target_d  = target_q;
        bd_sup_d  = 1'b0;
        unique case (pc_src)
            PC_SRC_HANDLER: begin
                pc_d      = HANDLER_PC;
                pending_d = 1'b0;
                bd_sup_d  = 1'b1;
            end
            PC_SRC_EPC: begin
                pc_d      = epc;
                pending_d = 1'b0;
                bd_sup_d  = 1'b1;
            end
            PC_SRC_HOLD: begin
                // A redirect resolved during a stall is kept until F may advance; newest wins.
                if (redirect_valid) begin
                    pending_d = 1'b1;
                    target_d  = redirect_pc;
                end
            end
            PC_SRC_REDIRECT: begin
                pc_d      = redirect_pc;
                pending_d = 1'b0;
            end
            PC_SRC_PENDING: begin
                pc_d      = target_q;
                pending_d = 1'b0;
            end
            default: begin
                pc_d = pc_plus4(pc_q);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            pending_q <= 1'b0;
            target_q  <= 32'h0;
            bd_sup_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pending_q <= pending_d;
            target_q  <= target_d;
            bd_sup_q  <= bd_sup_d;
        end
    end

    fetch_addr_check #(
        .IM_LO (IM_LO),
        .IM_HI (IM_HI)
    ) u_addr_check (
        .pc   (pc_q),
        .adel (adel)
    );

    assign imem_addr = pc_q;
    assign PC_4F     = pc_plus4(pc_q);
    assign InstrF    = adel ? NOP_INSTR : imem_rdata;
    assign ExcCodeF  = adel ? EXC_ADEL : EXC_NONE;
    // The first instruction at a handler or ERET target is never a delay slot.
    assign if_bdF    = is_bj_D & ~bd_sup_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed vectors push expected post-edge state, a monitor checks it.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        is_bj_D;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] InstrF;
    logic [31:0] PC_4F;
    logic [6:2]  ExcCodeF;
    logic        if_bdF;
    logic        pending_o;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        adel;
        logic        bd;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .exc_req        (exc_req),
        .eret_req       (eret_req),
        .epc            (epc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .is_bj_D        (is_bj_D),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .InstrF         (InstrF),
        .PC_4F          (PC_4F),
        .ExcCodeF       (ExcCodeF),
        .if_bdF         (if_bdF),
        .pending_o      (pending_o)
    );

    // Instruction memory: a recognisable word derived from the address.
    assign imem_rdata = {imem_addr[15:0], ~imem_addr[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: after each rising edge, compare DUT outputs to the oldest expectation.
    initial begin
        exp_t        e;
        logic [31:0] e_instr;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                e_instr = e.adel ? 32'h0 : {e.pc[15:0], ~e.pc[15:0]};
                check("imem_addr", imem_addr, e.pc);
                check("PC_4F",     PC_4F, e.pc + 32'd4);
                check("ExcCodeF",  {27'd0, ExcCodeF}, e.adel ? 32'd4 : 32'd0);
                check("InstrF",    InstrF, e_instr);
                check("pending_o", {31'd0, pending_o}, {31'd0, e.pend});
                check("if_bdF",    {31'd0, if_bdF}, {31'd0, e.bd});
            end
        end
    end

    // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
    task automatic step(input logic rst, input logic en_i, input logic exc_i, input logic eret_i,
                        input logic [31:0] epc_i, input logic rv, input logic [31:0] rpc,
                        input logic bj, input logic [31:0] e_pc, input logic e_pend,
                        input logic e_adel, input logic e_bd);
        exp_t e;
        @(negedge clk);
        reset          = rst;
        en             = en_i;
        exc_req        = exc_i;
        eret_req       = eret_i;
        epc            = epc_i;
        redirect_valid = rv;
        redirect_pc    = rpc;
        is_bj_D        = bj;
        e.pc   = e_pc;
        e.pend = e_pend;
        e.adel = e_adel;
        e.bd   = e_bd;
        sb_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en = 1'b0; exc_req = 1'b0; eret_req = 1'b0; epc = '0;
        redirect_valid = 1'b0; redirect_pc = '0; is_bj_D = 1'b0;

        //   rst en exc eret epc           rv rpc           bj  pc            pend adel bd
        step(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3000, 0, 0, 0);
        step(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3004, 0, 0, 0);
        step(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3008, 0, 0, 0);
        step(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_300C, 0, 0, 1);
        step(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3010, 0, 0, 0);
        // stalled redirect buffered, then taken when en returns
        step(0, 0, 0, 0, 32'h0,        1, 32'h0000_3100, 0, 32'h0000_3010, 1, 0, 0);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3010, 1, 0, 0);
        step(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3100, 0, 0, 0);
        step(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3104, 0, 0, 0);
        // overwrite of buffered target while still stalled
        step(0, 0, 0, 0, 32'h0,        1, 32'h0000_3200, 0, 32'h0000_3104, 1, 0, 0);
        step(0, 0, 0, 0, 32'h0,        1, 32'h0000_3300, 0, 32'h0000_3104, 1, 0, 0);
        step(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3300, 0, 0, 0);
        // live redirect beats buffered one
        step(0, 0, 0, 0, 32'h0,        1, 32'h0000_3400, 0, 32'h0000_3300, 1, 0, 0);
        step(0, 1, 0, 0, 32'h0,        1, 32'h0000_3500, 0, 32'h0000_3500, 0, 0, 0);
        step(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3504, 0, 0, 0);
        // misaligned target
        step(0, 1, 0, 0, 32'h0,        1, 32'h0000_3102, 0, 32'h0000_3102, 0, 1, 0);
        step(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3106, 0, 1, 0);
        // exception during stall with pending: clears buffer, suppresses delay-slot flag
        step(0, 0, 0, 0, 32'h0,        1, 32'h0000_3200, 0, 32'h0000_3106, 1, 1, 0);
        step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_4180, 0, 0, 0);
        step(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_4184, 0, 0, 1);
        // ERET beats redirect; exc beats ERET
        step(0, 1, 0, 1, 32'h0000_3020, 1, 32'h0000_3500, 1, 32'h0000_3020, 0, 0, 0);
        step(0, 1, 1, 1, 32'h0000_3020, 0, 32'h0,        0, 32'h0000_4180, 0, 0, 0);
        step(0, 0, 0, 0, 32'h0,        1, 32'h0000_3600, 0, 32'h0000_4180, 1, 0, 0);
        step(0, 0, 0, 1, 32'h0000_3040, 0, 32'h0,        0, 32'h0000_3040, 0, 0, 0);
        step(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3044, 0, 0, 0);
        // upper and lower window boundaries
        step(0, 1, 0, 0, 32'h0,        1, 32'h0000_6FFC, 0, 32'h0000_6FFC, 0, 0, 0);
        step(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_7000, 0, 1, 0);
        step(0, 1, 0, 0, 32'h0,        1, 32'h0000_2FFC, 0, 32'h0000_2FFC, 0, 1, 0);
        step(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3000, 0, 0, 0);
        // 32-bit wrap
        step(0, 1, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 1, 0);
        step(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 0, 1, 0);
        // reset in the middle of a stall drops the buffered redirect
        step(0, 0, 0, 0, 32'h0,        1, 32'h0000_3700, 0, 32'h0000_0000, 1, 1, 0);
        step(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3000, 0, 0, 0);
        step(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3004, 0, 0, 0);

        @(posedge clk);
        #2;
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
